// File: rtl/tile_pkg.sv
// Shared types and geometry for the tile draw arbiter.
// The 16-pixel tile is TILE_W x TILE_H. The step counter is sized to match.
package tile_pkg;

  localparam int TILE_W      = 4;
  localparam int TILE_H      = 4;
  localparam int X_W         = 8;
  localparam int Y_W         = 7;
  localparam int COLOUR_W    = 3;
  localparam int TILE_PIXELS = TILE_W * TILE_H;
  localparam int STEP_W      = $clog2(TILE_PIXELS);
  localparam int COL_W       = $clog2(TILE_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } tile_state_t;

endpackage

// File: rtl/tile_step_counter.sv
// Pixel step counter for one tile.
// A start pulse begins a 0..TILE_PIXELS-1 walk, with counting high throughout.
// The counter falls back to 0 and idle after the last step.
// A start that arrives while counting is ignored.
module tile_step_counter
  import tile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              counting,
  output logic [STEP_W-1:0] step
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TILE_PIXELS - 1);

  // Walk through the tile pixels once per start, then park at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      counting <= 1'b0;
      step     <= '0;
    end else if (counting) begin
      if (step == LAST_STEP) begin
        counting <= 1'b0;
        step     <= '0;
      end else begin
        step <= step + 1'b1;
      end
    end else if (start) begin
      counting <= 1'b1;
      step     <= '0;
    end
  end

endmodule

// File: rtl/tile_draw_arbiter.sv
// Round-robin arbiter sharing the VGA plot port among tile-drawing requesters.
// Optional feature macro: TILE_DRAW_ARBITER_ERASE_EN. It adds the req_erase port.
// With that feature, an erase tile is drawn in BG_COLOUR.
//
// state | meaning
// IDLE  | waiting; grants the round-robin winner when any req is high
// DRAW  | 16 pixel cycles, plot_en driven by the step counter
// DONE  | one-cycle ack to the granted requester, pointer advances
module tile_draw_arbiter
  import tile_pkg::*;
#(
  parameter int                      NUM_REQ   = 4,
  parameter logic [COLOUR_W-1:0]     BG_COLOUR = 3'b000
)
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*X_W-1:0]      req_x,
  input  logic [NUM_REQ*Y_W-1:0]      req_y,
  input  logic [NUM_REQ*COLOUR_W-1:0] req_colour,
`ifdef TILE_DRAW_ARBITER_ERASE_EN
  input  logic [NUM_REQ-1:0]          req_erase,
`endif
  output logic [NUM_REQ-1:0]          ack,
  output logic                        busy,
  output logic [X_W-1:0]              plot_x,
  output logic [Y_W-1:0]              plot_y,
  output logic [COLOUR_W-1:0]         plot_colour,
  output logic                        plot_en
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TILE_PIXELS - 1);

  tile_state_t         state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    grant;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    next_ptr;
  logic [X_W-1:0]      base_x;
  logic [Y_W-1:0]      base_y;
  logic [COLOUR_W-1:0] base_colour;
  logic                erase_q;
  logic                start;
  logic                counting;
  logic [STEP_W-1:0]   step;

  // Round-robin search from rr_ptr upward. The loop runs backwards so the nearest requester is written last.
  always_comb begin
    winner = rr_ptr;
    cand   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        winner = cand;
      end
    end
  end

  assign start    = (state == IDLE) && (|req);
  assign next_ptr = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  tile_step_counter u_step (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .counting (counting),
    .step     (step)
  );

  // Grant, tile latch, ack pulse and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      base_x      <= '0;
      base_y      <= '0;
      base_colour <= '0;
      erase_q     <= 1'b0;
      ack         <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= winner;
            base_x      <= req_x[int'(winner)*X_W +: X_W];
            base_y      <= req_y[int'(winner)*Y_W +: Y_W];
            base_colour <= req_colour[int'(winner)*COLOUR_W +: COLOUR_W];
`ifdef TILE_DRAW_ARBITER_ERASE_EN
            erase_q     <= req_erase[winner];
`else
            erase_q     <= 1'b0;
`endif
            state       <= DRAW;
          end
        end
        DRAW: begin
          if (step == LAST_STEP) begin
            ack   <= NUM_REQ'(1) << grant;
            state <= DONE;
          end
        end
        DONE: begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel outputs come only from the counter and latched tile, never straight from the requests.
  assign busy        = (state != IDLE);
  assign plot_en     = counting;
  assign plot_x      = counting ? base_x + X_W'(step[COL_W-1:0]) : '0;
  assign plot_y      = counting ? base_y + Y_W'(step[STEP_W-1:COL_W]) : '0;
  assign plot_colour = counting ? (erase_q ? BG_COLOUR : base_colour) : '0;

endmodule

// File: tb/tb_tile_draw_arbiter.sv
// Self-checking bench for tile_draw_arbiter.
// A phase-based tile model predicts every output on every cycle.
// It is backed by a directed vector table, hand sequences and random traffic.
module tb_tile_draw_arbiter;

  localparam int N = 4;
  localparam logic [2:0] BG = 3'b010;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*8-1:0] req_x;
  logic [N*7-1:0] req_y;
  logic [N*3-1:0] req_colour;
`ifdef TILE_DRAW_ARBITER_ERASE_EN
  logic [N-1:0]   req_erase;
`endif
  logic [N-1:0]   ack;
  logic           busy;
  logic [7:0]     plot_x;
  logic [6:0]     plot_y;
  logic [2:0]     plot_colour;
  logic           plot_en;

  tile_draw_arbiter #(.NUM_REQ(N), .BG_COLOUR(BG)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_colour  (req_colour),
`ifdef TILE_DRAW_ARBITER_ERASE_EN
    .req_erase   (req_erase),
`endif
    .ack         (ack),
    .busy        (busy),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_colour (plot_colour),
    .plot_en     (plot_en)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: m_p counts cycles since the grant edge (0 = idle, 1..16 pixels, 17 ack).
  int m_p   = 0;
  int m_ptr = 0;
  int m_g   = 0;
  int m_x, m_y, m_c;
  bit m_e   = 1'b0;
  bit m_rst = 1'b0;

  logic [N-1:0] keep_mask;
  int obs_x[$];
  int obs_y[$];
  int obs_c[$];
  int ack_idx_q[$];
  int ack_val_q[$];
  int ack_cyc_q[$];

  typedef struct {
    int idx; int x; int y; int col;
    int fx; int fy; int lx; int ly; int ackv;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int i, input int x, input int y, input int c);
    req_x[i*8 +: 8]      = 8'(x);
    req_y[i*7 +: 7]      = 7'(y);
    req_colour[i*3 +: 3] = 3'(c);
    req[i]               = 1'b1;
  endtask

  task automatic clear_obs();
    obs_x.delete(); obs_y.delete(); obs_c.delete();
    ack_idx_q.delete(); ack_val_q.delete(); ack_cyc_q.delete();
  endtask

  // Advance one clock: update the model from the inputs, clock, check, then respond to acks.
  task automatic step();
    int  j;
    int  c;
    bit  found;
    if (reset) begin
      m_p = 0; m_ptr = 0; m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (m_p == 0) begin
        if (req != '0) begin
          found = 1'b0;
          for (int i = 0; i < N; i++) begin
            c = (m_ptr + i) % N;
            if (!found && req[c]) begin m_g = c; found = 1'b1; end
          end
          m_x = int'(req_x[m_g*8 +: 8]);
          m_y = int'(req_y[m_g*7 +: 7]);
          m_c = int'(req_colour[m_g*3 +: 3]);
`ifdef TILE_DRAW_ARBITER_ERASE_EN
          m_e = req_erase[m_g];
`else
          m_e = 1'b0;
`endif
          m_p = 1;
        end
      end else if (m_p == 17) begin
        m_p = 0;
        m_ptr = (m_g + 1) % N;
      end else begin
        m_p++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    j = m_p - 1;
    chk("plot_en", int'(plot_en), (m_p >= 1 && m_p <= 16) ? 1 : 0);
    chk("busy", int'(busy), (m_p >= 1) ? 1 : 0);
    chk("ack", int'(ack), (m_p == 17) ? (1 << m_g) : 0);
    if (m_p >= 1 && m_p <= 16) begin
      chk("plot_x", int'(plot_x), (m_x + j % 4) % 256);
      chk("plot_y", int'(plot_y), (m_y + j / 4) % 128);
      chk("plot_colour", int'(plot_colour), m_e ? int'(BG) : m_c);
    end else if (m_rst) begin
      chk("rst_plot_x", int'(plot_x), 0);
      chk("rst_plot_y", int'(plot_y), 0);
      chk("rst_plot_colour", int'(plot_colour), 0);
    end
    if (plot_en) begin
      obs_x.push_back(int'(plot_x));
      obs_y.push_back(int'(plot_y));
      obs_c.push_back(int'(plot_colour));
    end
    if (ack != '0) begin
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          ack_idx_q.push_back(i);
          ack_val_q.push_back(int'(ack));
          ack_cyc_q.push_back(cyc);
          if (!keep_mask[i]) req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_acks(input int n, input int bound);
    int k = 0;
    while (ack_idx_q.size() < n && k < bound) begin
      step();
      k++;
    end
    chk("ack_count_or_timeout", ack_idx_q.size(), n);
  endtask

  initial begin
    int s;
    vt[0] = '{idx:0, x:10,  y:20,  col:5, fx:10,  fy:20,  lx:13, ly:23, ackv:4'b0001};
    vt[1] = '{idx:1, x:254, y:126, col:6, fx:254, fy:126, lx:1,  ly:1,  ackv:4'b0010};
    vt[2] = '{idx:3, x:255, y:127, col:1, fx:255, fy:127, lx:2,  ly:2,  ackv:4'b1000};
    vt[3] = '{idx:2, x:0,   y:0,   col:3, fx:0,   fy:0,   lx:3,  ly:3,  ackv:4'b0100};

    reset = 1'b1; req = '0; req_x = '0; req_y = '0; req_colour = '0; keep_mask = '0;
`ifdef TILE_DRAW_ARBITER_ERASE_EN
    req_erase = '0;
`endif
    step(); step();
    chk("reset_ack", int'(ack), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_plot_en", int'(plot_en), 0);
    reset = 1'b0;
    step();

    // Directed single-tile vectors, including the coordinate wrap cases.
    foreach (vt[v]) begin
      clear_obs();
      set_req(vt[v].idx, vt[v].x, vt[v].y, vt[v].col);
      s = cyc;
      wait_acks(1, 40);
      if (ack_idx_q.size() > 0) begin
        chk("vec_ack", ack_val_q[0], vt[v].ackv);
        chk("vec_latency", ack_cyc_q[0] - s, 17);
      end
      chk("vec_npix", obs_x.size(), 16);
      if (obs_x.size() == 16) begin
        chk("vec_first_x", obs_x[0], vt[v].fx);
        chk("vec_first_y", obs_y[0], vt[v].fy);
        chk("vec_last_x", obs_x[15], vt[v].lx);
        chk("vec_last_y", obs_y[15], vt[v].ly);
      end
      step();
    end

    // Full contention: acks in order 0,1,2,3 and 18 cycles apart.
    reset = 1'b1; step(); reset = 1'b0;
    clear_obs();
    for (int i = 0; i < N; i++) set_req(i, $urandom_range(255), $urandom_range(127), $urandom_range(7));
    wait_acks(4, 100);
    if (ack_idx_q.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("cont_order", ack_idx_q[k], k);
      for (int k = 1; k < 4; k++) chk("cont_spacing", ack_cyc_q[k] - ack_cyc_q[k-1], 18);
    end
    chk("cont_npix", obs_x.size(), 64);
    step();

    // Fairness: requesters 1 and 3 keep re-requesting.
    reset = 1'b1; step(); reset = 1'b0;
    clear_obs();
    keep_mask = 4'b1010;
    set_req(1, 40, 40, 2);
    set_req(3, 80, 60, 4);
    wait_acks(6, 150);
    if (ack_idx_q.size() == 6)
      for (int k = 0; k < 6; k++) chk("rr_alternate", ack_idx_q[k], (k % 2 == 0) ? 1 : 3);
    keep_mask = '0;
    req = '0;
    step(); step();

    // Reset in the middle of a tile, then a fresh request to requester 2.
    clear_obs();
    set_req(0, 100, 50, 7);
    s = 0;
    while (obs_x.size() < 7 && s < 30) begin step(); s++; end
    chk("mid_reset_reach_pixel7", obs_x.size(), 7);
    reset = 1'b1; req = '0;
    step();
    chk("mid_reset_plot_en", int'(plot_en), 0);
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_ack", int'(ack), 0);
    reset = 1'b0;
    clear_obs();
    set_req(2, 30, 30, 1);
    s = cyc;
    wait_acks(1, 40);
    if (ack_idx_q.size() > 0) begin
      chk("post_reset_ack", ack_val_q[0], 4'b0100);
      chk("post_reset_latency", ack_cyc_q[0] - s, 17);
    end
    chk("post_reset_npix", obs_x.size(), 16);
    step();

`ifdef TILE_DRAW_ARBITER_ERASE_EN
    // Erase tile is drawn entirely in the background colour.
    clear_obs();
    req_erase[1] = 1'b1;
    set_req(1, 5, 5, 7);
    wait_acks(1, 40);
    s = 0;
    foreach (obs_c[k]) if (obs_c[k] == int'(BG)) s++;
    chk("erase_bg_pixels", s, 16);
    req_erase = '0;
    step();
`endif

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(3) == 0) begin
          set_req(i, $urandom_range(255), $urandom_range(127), $urandom_range(7));
`ifdef TILE_DRAW_ARBITER_ERASE_EN
          req_erase[i] = $urandom_range(1) == 1;
`endif
        end
      end
      reset = ($urandom_range(399) == 0);
      step();
    end
    reset = 1'b0;
    req = '0;
    for (int n = 0; n < 20; n++) step();
    chk("final_idle_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tile_draw_arbiter.md
# tile_draw_arbiter

Shares the single VGA plot port among several tile-drawing requesters. Each requester asks for one 4x4 tile at a base coordinate and colour. The arbiter grants requesters round-robin and walks the 16 pixels of the granted tile with an internal 0..15 step counter, asserting `plot_en` once per pixel. It then acknowledges the requester. It sits between the game/render FSMs and the VGA adapter's `x`/`y`/`colour`/`writeEn` inputs.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `BG_COLOUR`, 3'b000, colour used for erase requests (only with `TILE_DRAW_ARBITER_ERASE_EN`)

Ports:
- `clk`  in  1  clock; all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  NUM_REQ  per-requester draw request; held high until that requester's `ack`
- `req_x`  in  NUM_REQ*8  packed base x; requester i at [8i+7:8i]
- `req_y`  in  NUM_REQ*7  packed base y; requester i at [7i+6:7i]
- `req_colour`  in  NUM_REQ*3  packed colour; requester i at [3i+2:3i]
- `req_erase`  in  NUM_REQ  erase flag per requester (port exists only with `TILE_DRAW_ARBITER_ERASE_EN`)
- `ack`  out  NUM_REQ  one-hot, one-cycle pulse: granted tile finished
- `busy`  out  1  high in DRAW and DONE
- `plot_x`  out  8  pixel x to VGA adapter
- `plot_y`  out  7  pixel y to VGA adapter
- `plot_colour`  out  3  pixel colour
- `plot_en`  out  1  VGA writeEn; high exactly for the 16 pixel cycles

## Operation
- States:
  - IDLE: `plot_en`=0. If any `req` bit is high, select the winner round-robin. Search starts at `rr_ptr` and increases modulo NUM_REQ. Latch the winner's x, y, colour and index, clear `step`, go to DRAW. If no `req` bit is high, stay in IDLE.
  - DRAW: `plot_en`=1, `plot_x`=base_x+step[1:0], `plot_y`=base_y+step[3:2], `plot_colour`=latched colour. Increment `step` each cycle. When `step`==15, go to DONE.
  - DONE: `ack[grant]`=1 for one cycle. Set `rr_ptr`=(grant+1) mod NUM_REQ. Go to IDLE.
- `plot_en` is decoded from the step counter's `counting` flag, not from the FSM state. It can never stay high past pixel 15.
- Pixel order is row-major: (0,0),(1,0),(2,0),(3,0),(0,1)…(3,3).
- Arithmetic: x additions wrap modulo 256 and y additions modulo 128. There is no clipping.
- Request inputs are ignored outside IDLE. Dropping `req` mid-tile does not abort the tile; it completes and is acked.
- Requesters must deassert `req` at the clock edge that ends the `ack` cycle. A `req` still high in the following IDLE cycle is treated as a new request.
- Reset (at any state, including mid-DRAW) takes effect at the next posedge:
  - state=IDLE, `step`=0, `rr_ptr`=0, latched grant=0
  - all outputs 0: `ack`=0, `busy`=0, `plot_en`=0, `plot_x`=0, `plot_y`=0, `plot_colour`=0

## Timing
- `req` seen high at edge k: first pixel at edge k+1, last pixel at edge k+16. `ack` is high during the cycle after edge k+16, and the state is IDLE after edge k+17.
- Minimum tile period: 18 cycles (1 IDLE + 16 DRAW + 1 DONE).
- Under continuous contention from all requesters, each one is served once every NUM_REQ×18 cycles.
- All outputs are registered or decoded from registered state. There are no combinational paths from `req*` inputs to outputs.

## Configuration
- `TILE_DRAW_ARBITER_ERASE_EN` defined:
  - adds the `req_erase` port
  - `req_erase[i]` is latched along with the grant
  - if it is set, `plot_colour`=`BG_COLOUR` for the whole tile
- `TILE_DRAW_ARBITER_ERASE_EN` undefined: the port is absent, and `plot_colour` is always the latched `req_colour`.

## Structure
- Shared package `tile_pkg` holds:
  - state typedef (IDLE, DRAW, DONE)
  - `TILE_W`=4, `TILE_H`=4, `X_W`=8, `Y_W`=7, `COLOUR_W`=3
- Sub-module `tile_step_counter`:
  - inputs: `clk`, `reset`, `start`
  - outputs: `counting`, `step[3:0]`
  - counts 0..15 after `start`
  - clears `counting` and returns to 0 after 15
  - `start` is ignored while counting
- The arbiter instantiates this sub-module and derives `plot_en` from `counting`.

## Test plan
- Single request: requester 0, x=10, y=20, colour=3'b101. The 16 `plot_en` cycles cover x 10..13 and y 20..23 in row-major order, and `ack`=4'b0001 occurs once, 17 cycles after the request edge.
- Contention: `req`=4'b1111 held, each requester dropping on its ack. Acks arrive in order 0,1,2,3, spaced 18 cycles apart, with no `plot_en` gap inside any tile.
- Round-robin fairness: requesters 1 and 3 request continuously, re-raising after each ack. Grants alternate 1,3,1,3, and requester 1 never wins twice in a row.
- Wrap: x=254, y=126. Pixels have x ∈ {254,255,0,1} and y ∈ {126,127,0,1}.
- Reset asserted at the 7th pixel: at the next edge `plot_en`=0, `busy`=0, `ack`=0. A fresh request to requester 2 is then granted first (`rr_ptr`=0 search reaches 2) and drawn fully.
- With `TILE_DRAW_ARBITER_ERASE_EN`: `req_erase[1]`=1 and colour=3'b111 give `plot_colour`=`BG_COLOUR` on all 16 pixels.
